ocl_axil_reg_bridge: RTL and testbench

- AXI4-Lite slave front end on the OCL BAR0 path. Sits directly downstream of the AXI-Lite register slice and directly upstream of the Ising core's register interface.
- Converts single-beat AXI-Lite reads and writes into simple one-cycle register strobes.
- Adds a read timeout and address-range decode, so a hung or unmapped access can never wedge the PCIe host.

---
 rtl/ocl_axil_pkg.sv | 21 ++
 rtl/ocl_axil_rd_timer.sv | 34 +++
 rtl/ocl_axil_reg_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_ocl_axil_reg_bridge.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocl_axil_pkg.sv
// Shared response codes, error data and FSM state types for the OCL AXI-Lite register bridge.
package ocl_axil_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_ISSUE = 2'd1,
        W_RESP  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ocl_axil_rd_timer.sv
// Loadable 16-bit read-wait counter; tc_o marks the last cycle of the allowed wait window.
module ocl_axil_rd_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [15:0] cnt_q, cnt_d;

    // Count reaches LIMIT at the end of the LIMIT-th wait cycle, so flag one value early.
    assign tc_o = (cnt_q == 16'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ocl_axil_reg_bridge.sv
// AXI4-Lite slave to one-cycle register strobes, with address-range decode and read timeout.
// Handshake: a beat transfers on a rising edge where valid and ready are both high; valid never waits on ready.
module ocl_axil_reg_bridge
    import ocl_axil_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          DATA_W     = 32,
    parameter logic [ADDR_W-1:0]    ADDR_LIMIT = 'h0001_0000,
    parameter int unsigned          RD_TIMEOUT = 255
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main_n,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  reg_wr_en,
    output logic [ADDR_W-1:0]     reg_wr_addr,
    output logic [DATA_W-1:0]     reg_wr_data,
    output logic [DATA_W/8-1:0]   reg_wr_strb,
    output logic                  reg_rd_en,
    output logic [ADDR_W-1:0]     reg_rd_addr,
    input  logic                  reg_rd_ack,
    input  logic [DATA_W-1:0]     reg_rd_data
);

    localparam int unsigned STRB_W = DATA_W / 8;

    wr_state_t           wr_state_q, wr_state_d;
    logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                awready_q, awready_d, wready_q, wready_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                wr_in_range;

    rd_state_t           rd_state_q, rd_state_d;
    logic                arready_q, arready_d;
    logic                rd_first_q, rd_first_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                tmr_load, tmr_en, tmr_tc;

    assign wr_in_range = (awaddr_q < ADDR_LIMIT);

    assign s_awready   = awready_q;
    assign s_wready    = wready_q;
    assign s_bvalid    = (wr_state_q == W_RESP);
    assign s_bresp     = bresp_q;
    assign reg_wr_en   = (wr_state_q == W_ISSUE) && wr_in_range;
    assign reg_wr_addr = awaddr_q;
    assign reg_wr_data = wdata_q;
    assign reg_wr_strb = wstrb_q;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (s_awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_awaddr;
                end
                if (s_wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    wr_state_d = W_ISSUE;
                end
            end
            W_ISSUE: begin
                bresp_d    = wr_in_range ? RESP_OKAY : RESP_DECERR;
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
                wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (s_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        // Readies are registered so they read 0 while held in reset.
        awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    assign s_arready   = arready_q;
    assign s_rvalid    = (rd_state_q == R_RESP);
    assign s_rdata     = rdata_q;
    assign s_rresp     = rresp_q;
    assign reg_rd_en   = rd_first_q;
    assign reg_rd_addr = araddr_q;
    assign tmr_en      = (rd_state_q == R_WAIT);

    always_comb begin
        rd_state_d = rd_state_q;
        rd_first_d = 1'b0;
        araddr_d   = araddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        tmr_load   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (s_arvalid && arready_q) begin
                    araddr_d = s_araddr;
                    if (s_araddr < ADDR_LIMIT) begin
                        tmr_load   = 1'b1;
                        rd_first_d = 1'b1;
                        rd_state_d = R_WAIT;
                    end else begin
                        rdata_d    = '0;
                        rresp_d    = RESP_DECERR;
                        rd_state_d = R_RESP;
                    end
                end
            end
            R_WAIT: begin
                // Ack is checked before the timeout so a same-cycle ack wins.
                if (reg_rd_ack) begin
                    rdata_d    = reg_rd_data;
                    rresp_d    = RESP_OKAY;
                    rd_state_d = R_RESP;
                end else if (tmr_tc) begin
                    rdata_d    = DATA_W'(RD_ERR_DATA);
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rd_first_q <= 1'b0;
            araddr_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rd_first_q <= rd_first_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    ocl_axil_rd_timer #(
        .LIMIT (RD_TIMEOUT)
    ) u_rd_timer (
        .clk_i   (clk_main_a0),
        .rst_n_i (rst_main_n),
        .load_i  (tmr_load),
        .en_i    (tmr_en),
        .tc_o    (tmr_tc)
    );

endmodule

// File: tb/tb_ocl_axil_reg_bridge.sv
// Directed, table-driven bench for the OCL AXI-Lite register bridge.
module tb_ocl_axil_reg_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_TO  = 8;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_n  = 1'b1;
    logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;
    logic [3:0]  s_wstrb = 0;
    logic        reg_rd_ack = 0;
    logic [31:0] reg_rd_data = 0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, reg_wr_addr, reg_wr_data, reg_rd_addr;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_en, reg_rd_en;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;

    always #5 clk_main_a0 = ~clk_main_a0;

    ocl_axil_reg_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_LIMIT(32'h0001_0000), .RD_TIMEOUT(RD_TO)
    ) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_strb(reg_wr_strb), .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
        .reg_rd_ack(reg_rd_ack), .reg_rd_data(reg_rd_data)
    );

    always @(negedge clk_main_a0) begin
        if (reg_wr_en) wr_pulses++;
        if (reg_rd_en) rd_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=0x%08h exp=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        logic any;
        any = |{s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
                reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_strb, reg_rd_en, reg_rd_addr};
        check(name, {31'b0, any}, 32'd0);
    endtask

    typedef struct {
        int          aw_dly;
        int          w_dly;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        exp_en;
        logic [1:0]  exp_resp;
    } wr_vec_t;

    typedef struct {
        logic [31:0] addr;
        int          ack_dly;
        logic [31:0] data;
        logic        exp_en;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
        int          lat_min;
        int          lat_max;
        int          hold;
        logic        late_ack;
    } rd_vec_t;

    task automatic do_write(input wr_vec_t v, input string tag);
        int   c, p0;
        logic aw_done, w_done, aw_hs, w_hs;
        p0 = wr_pulses; c = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && c < 50) begin
            @(negedge clk_main_a0);
            s_awaddr  = v.addr; s_wdata = v.data; s_wstrb = v.strb;
            s_awvalid = !aw_done && (c >= v.aw_dly);
            s_wvalid  = !w_done && (c >= v.w_dly);
            if (aw_done != w_done)
                check({tag, " ready_drop"}, {31'b0, aw_done ? s_awready : s_wready}, 32'd0);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge clk_main_a0);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            c++;
        end
        check({tag, " handshake"}, {30'b0, aw_done, w_done}, 32'd3);
        @(negedge clk_main_a0);
        s_awvalid = 0; s_wvalid = 0;
        if (!(aw_done && w_done)) return;
        check({tag, " wr_en"}, {31'b0, reg_wr_en}, {31'b0, v.exp_en});
        if (v.exp_en) begin
            check({tag, " wr_addr"}, reg_wr_addr, v.addr);
            check({tag, " wr_data"}, reg_wr_data, v.data);
            check({tag, " wr_strb"}, {28'b0, reg_wr_strb}, {28'b0, v.strb});
        end
        check({tag, " bvalid_early"}, {31'b0, s_bvalid}, 32'd0);
        @(negedge clk_main_a0);
        check({tag, " bvalid"}, {31'b0, s_bvalid}, 32'd1);
        check({tag, " bresp"}, {30'b0, s_bresp}, {30'b0, v.exp_resp});
        s_bready = 1;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        s_bready = 0;
        check({tag, " bvalid_drop"}, {31'b0, s_bvalid}, 32'd0);
        check({tag, " wr_pulses"}, wr_pulses - p0, {31'b0, v.exp_en});
    endtask

    task automatic do_read(input rd_vec_t v, input string tag);
        int k, lat, p0, bad;
        p0 = rd_pulses; lat = 0; bad = 0;
        @(negedge clk_main_a0);
        s_arvalid = 1; s_araddr = v.addr;
        check({tag, " arready"}, {31'b0, s_arready}, 32'd1);
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        s_arvalid = 0;
        for (k = 1; k < 40; k++) begin
            if (k == 1) check({tag, " rd_en"}, {31'b0, reg_rd_en}, {31'b0, v.exp_en});
            if (k == 1 && v.exp_en) check({tag, " rd_addr"}, reg_rd_addr, v.addr);
            if (s_rvalid) begin
                lat = k;
                break;
            end
            reg_rd_ack  = (k - 1 == v.ack_dly);
            reg_rd_data = v.data;
            @(posedge clk_main_a0);
            @(negedge clk_main_a0);
            reg_rd_ack = 0;
        end
        checks++;
        if (lat < v.lat_min || lat > v.lat_max) begin
            errors++;
            $display("FAIL %s latency: act=%0d exp=%0d..%0d (0 = no rvalid)", tag, lat, v.lat_min, v.lat_max);
        end
        check({tag, " rdata"}, s_rdata, v.exp_rdata);
        check({tag, " rresp"}, {30'b0, s_rresp}, {30'b0, v.exp_rresp});
        for (int h = 0; h < v.hold; h++) begin
            reg_rd_ack  = v.late_ack && (h == 2);
            reg_rd_data = 32'hFFFF_FFFF;
            @(posedge clk_main_a0);
            @(negedge clk_main_a0);
            reg_rd_ack = 0;
            if (!s_rvalid || s_rdata !== v.exp_rdata || s_rresp !== v.exp_rresp) bad++;
        end
        if (v.hold > 0) check({tag, " hold_stable_bad"}, bad, 32'd0);
        s_rready = 1;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        s_rready = 0;
        check({tag, " rvalid_drop"}, {31'b0, s_rvalid}, 32'd0);
        if (v.late_ack) begin
            reg_rd_ack = 1; reg_rd_data = 32'h5555_5555;
            bad = 0;
            for (int h = 0; h < 4; h++) begin
                @(posedge clk_main_a0);
                @(negedge clk_main_a0);
                reg_rd_ack = 0;
                if (s_rvalid) bad++;
            end
            check({tag, " late_ack_spurious"}, bad, 32'd0);
        end
        check({tag, " rd_pulses"}, rd_pulses - p0, {31'b0, v.exp_en});
    endtask

    wr_vec_t wv[6];
    rd_vec_t rv[5];

    initial begin
        int p0;
        wv[0] = '{0, 3, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 1'b1, 2'b00};
        wv[1] = '{3, 0, 32'h0000_0014, 32'h0000_BEEF, 4'h3, 1'b1, 2'b00};
        wv[2] = '{0, 0, 32'h0000_0018, 32'hCAFE_F00D, 4'h9, 1'b1, 2'b00};
        wv[3] = '{0, 0, 32'h0001_0000, 32'h1111_2222, 4'hF, 1'b0, 2'b11};
        wv[4] = '{1, 1, 32'h0000_FFFC, 32'h0000_0011, 4'h1, 1'b1, 2'b00};
        wv[5] = '{2, 0, 32'hFFFF_FFF0, 32'h7777_7777, 4'hF, 1'b0, 2'b11};
        rv[0] = '{32'h0000_0020, 0, 32'h1234_5678, 1'b1, 32'h1234_5678, 2'b00, 2, 2, 5, 1'b0};
        rv[1] = '{32'h0000_0028, 3, 32'h0BAD_CAFE, 1'b1, 32'h0BAD_CAFE, 2'b00, 5, 5, 0, 1'b0};
        rv[2] = '{32'h0000_0024, -1, 32'h0, 1'b1, 32'hDEAD_BEEF, 2'b10, RD_TO + 1, RD_TO + 2, 4, 1'b1};
        rv[3] = '{32'h0001_0000, -1, 32'h0, 1'b0, 32'h0, 2'b11, 1, 1, 0, 1'b0};
        rv[4] = '{32'h0000_FFFC, RD_TO - 1, 32'h600D_0ACE, 1'b1, 32'h600D_0ACE, 2'b00, RD_TO + 1, RD_TO + 1, 0, 1'b0};

        #1 rst_main_n = 0;
        repeat (2) @(negedge clk_main_a0);
        check_zero("reset_outputs");
        rst_main_n = 1;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        check("idle_readys", {29'b0, s_awready, s_wready, s_arready}, 32'd7);

        for (int i = 0; i < 6; i++) do_write(wv[i], $sformatf("wr%0d", i));
        for (int i = 0; i < 5; i++) do_read(rv[i], $sformatf("rd%0d", i));

        // Concurrent write 0x30 / read 0x34 accepted on the same edge.
        @(negedge clk_main_a0);
        s_awvalid = 1; s_awaddr = 32'h30; s_wvalid = 1; s_wdata = 32'h3030_3030; s_wstrb = 4'hF;
        s_arvalid = 1; s_araddr = 32'h34;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        check("conc strobes", {30'b0, reg_wr_en, reg_rd_en}, 32'd3);
        check("conc wr_addr", reg_wr_addr, 32'h30);
        check("conc rd_addr", reg_rd_addr, 32'h34);
        reg_rd_ack = 1; reg_rd_data = 32'h0000_3434;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        reg_rd_ack = 0;
        check("conc both_valid", {30'b0, s_bvalid, s_rvalid}, 32'd3);
        s_bready = 1;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        s_bready = 0;
        check("conc b_done_r_held", {30'b0, s_bvalid, s_rvalid}, 32'd1);
        check("conc rdata", s_rdata, 32'h0000_3434);
        s_rready = 1;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        s_rready = 0;
        check("conc r_done", {31'b0, s_rvalid}, 32'd0);

        // Reset in the middle of R_WAIT.
        s_arvalid = 1; s_araddr = 32'h40;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        s_arvalid = 0;
        repeat (3) @(negedge clk_main_a0);
        #2 rst_main_n = 0;
        #1 check_zero("rst_rwait zero");
        repeat (2) @(negedge clk_main_a0);
        rst_main_n = 1;
        p0 = rd_pulses;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        check("rst_rwait readys", {29'b0, s_awready, s_wready, s_arready}, 32'd7);
        reg_rd_ack = 1; reg_rd_data = 32'h9999_9999;
        repeat (4) begin
            @(posedge clk_main_a0);
            @(negedge clk_main_a0);
            reg_rd_ack = 0;
        end
        check("rst_rwait no_rvalid", {31'b0, s_rvalid}, 32'd0);
        check("rst_rwait no_rd_en", rd_pulses - p0, 32'd0);

        // Reset while the write response is pending.
        s_awvalid = 1; s_awaddr = 32'h50; s_wvalid = 1; s_wdata = 32'h5050_5050;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        s_awvalid = 0; s_wvalid = 0;
        @(negedge clk_main_a0);
        check("rst_wresp bvalid_before", {31'b0, s_bvalid}, 32'd1);
        #2 rst_main_n = 0;
        #1 check_zero("rst_wresp zero");
        repeat (2) @(negedge clk_main_a0);
        rst_main_n = 1;
        p0 = wr_pulses;
        repeat (3) begin
            @(posedge clk_main_a0);
            @(negedge clk_main_a0);
        end
        check("rst_wresp readys", {29'b0, s_awready, s_wready, s_arready}, 32'd7);
        check("rst_wresp no_bvalid", {31'b0, s_bvalid}, 32'd0);
        check("rst_wresp no_wr_en", wr_pulses - p0, 32'd0);

        // The bridge still works after both aborts.
        do_write(wv[0], "post_rst_wr");
        do_read(rv[1], "post_rst_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
